// File: rtl/dmem_responder_if.sv
// Request/response/SRAM bundle between the MEM stage, dmem_responder and the SRAM.
// The master side is the pipeline plus the SRAM read port; the slave side is the responder.
interface dmem_responder_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic [1:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wrstb;
  logic              req_ready;
  logic              stall;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_wrstb, sram_rdata,
    input  req_ready, stall, rsp_valid, rsp_rdata, rsp_err,
           sram_en, sram_we, sram_addr, sram_wdata
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_wrstb, sram_rdata,
    output req_ready, stall, rsp_valid, rsp_rdata, rsp_err,
           sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one LOAD/STORE at a time from the MEM stage,
// waits WAIT_STATES cycles, performs a single SRAM access and returns a
// one-cycle response. Optional macro DMEM_MISALIGN_CHECK_EN short-circuits
// misaligned requests to an error response without touching the SRAM.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1
) (
  input logic              clk,
  input logic              rst_n,
  dmem_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [3:0] WS       = WAIT_STATES[3:0];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_store_q, is_store_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wrstb_q, wrstb_d;
  logic              sram_en_q, sram_en_d;
  logic [3:0]        sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]       sram_wdata_q, sram_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              req_is_mem, accept, misalign;
  logic              unused_addr_bits;

  // Upper address bits wrap; the byte offset only matters to the misalign check.
  assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};

  // Request qualification and misalignment decode on the live request.
  always_comb begin
    req_is_mem = bus.req_valid && (bus.req_op == OP_LOAD || bus.req_op == OP_STORE);
    accept     = (state_q == IDLE) && req_is_mem;
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = ((bus.req_wrstb == 4'b1111) && (bus.req_addr[1:0] != 2'b00)) ||
               (((bus.req_wrstb == 4'b0011) || (bus.req_wrstb == 4'b1100)) && bus.req_addr[0]);
`else
    misalign = 1'b0;
`endif
  end

  // Next-state, latched request and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_store_d   = is_store_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wrstb_d      = wrstb_q;
    rdata_d      = rdata_q;
    rsp_err_d    = 1'b0;
    sram_en_d    = 1'b0;
    sram_we_d    = 4'b0000;
    sram_addr_d  = '0;
    sram_wdata_d = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          is_store_d = (bus.req_op == OP_STORE);
          waddr_d    = bus.req_addr[ADDR_W+1:2];
          wdata_d    = bus.req_wdata;
          wrstb_d    = bus.req_wrstb;
          if (misalign) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = WS;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (!is_store_q && !rsp_err_q) rdata_d = bus.sram_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // ACCESS lasts one cycle, so state_d==ACCESS only on entry; use _d so a
    // zero-wait accept drives the freshly latched fields.
    if (state_d == ACCESS) begin
      sram_en_d    = 1'b1;
      sram_we_d    = is_store_d ? wrstb_d : 4'b0000;
      sram_addr_d  = waddr_d;
      sram_wdata_d = wdata_d;
    end
    rsp_valid_d = (state_d == RESP);
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_store_q   <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wrstb_q      <= '0;
      rdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_store_q   <= is_store_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wrstb_q      <= wrstb_d;
      rdata_q      <= rdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  // SRAM read data lands in the RESP cycle, so a load response forwards it
  // directly and the held copy takes over from the next cycle on.
  assign bus.rsp_rdata  = (state_q == RESP && !is_store_q && !rsp_err_q) ? bus.sram_rdata : rdata_q;
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.stall      = req_is_mem && !rsp_valid_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.sram_en    = sram_en_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_wdata = sram_wdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_STATES=1 instance driven from a
// vector table plus reset/idle sequences, and a WAIT_STATES=0 instance for latency.
module tb_dmem_responder;
  localparam int AW  = 12;
  localparam int WS1 = 1;
  localparam logic [1:0] LD = 2'b01;
  localparam logic [1:0] ST = 2'b10;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wrstb;
    logic        mis;
    logic [11:0] eaddr;
    logic [3:0]  ewe;
    logic [31:0] erd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vt[11];
  logic [31:0] w4;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(AW)) b1();
  dmem_responder_if #(.ADDR_W(AW)) b0();

  dmem_responder #(.ADDR_W(AW), .WAIT_STATES(WS1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(b1));
  dmem_responder #(.ADDR_W(AW), .WAIT_STATES(0))   u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  logic [31:0] mem1 [0:4095];
  logic [31:0] mem0 [0:4095];

  always @(posedge clk) begin
    if (b1.sram_en) begin
      for (int i = 0; i < 4; i++)
        if (b1.sram_we[i]) mem1[b1.sram_addr][8*i +: 8] <= b1.sram_wdata[8*i +: 8];
      b1.sram_rdata <= mem1[b1.sram_addr];
    end
  end

  always @(posedge clk) begin
    if (b0.sram_en) begin
      for (int j = 0; j < 4; j++)
        if (b0.sram_we[j]) mem0[b0.sram_addr][8*j +: 8] <= b0.sram_wdata[8*j +: 8];
      b0.sram_rdata <= mem0[b0.sram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One request on the WAIT_STATES=1 instance, checked cycle by cycle.
  task automatic xact(input vec_t v, input int id);
    int ten, trsp;
    ten  = v.mis ? -1 : 1 + WS1;
    trsp = v.mis ? 1 : 2 + WS1;
    @(posedge clk); #1;
    b1.req_valid = 1'b1; b1.req_op = v.op; b1.req_addr = v.addr;
    b1.req_wdata = v.wdata; b1.req_wrstb = v.wrstb;
    for (int k = 0; k <= trsp; k++) begin
      @(negedge clk);
      if (k == 0) chk($sformatf("v%0d ready", id), 32'(b1.req_ready), 32'd1);
      chk($sformatf("v%0d k%0d stall", id, k), 32'(b1.stall), 32'(k != trsp));
      chk($sformatf("v%0d k%0d sram_en", id, k), 32'(b1.sram_en), 32'(k == ten));
      chk($sformatf("v%0d k%0d rsp_valid", id, k), 32'(b1.rsp_valid), 32'(k == trsp));
      if (k == ten) begin
        chk($sformatf("v%0d sram_addr", id), 32'(b1.sram_addr), 32'(v.eaddr));
        chk($sformatf("v%0d sram_we", id), 32'(b1.sram_we), 32'(v.ewe));
        if (v.op == ST) chk($sformatf("v%0d sram_wdata", id), b1.sram_wdata, v.wdata);
      end
      if (k == trsp) begin
        chk($sformatf("v%0d rsp_rdata", id), b1.rsp_rdata, v.erd);
        chk($sformatf("v%0d rsp_err", id), 32'(b1.rsp_err), 32'(v.mis));
      end
      if (k == 0) begin
        // Corrupt the live request after accept; the latched copy must be used.
        @(posedge clk); #1;
        b1.req_addr = ~v.addr; b1.req_wdata = ~v.wdata; b1.req_wrstb = ~v.wrstb;
      end
    end
  endtask

  // One request on the WAIT_STATES=0 instance.
  task automatic x0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] erd, input int id);
    @(posedge clk); #1;
    b0.req_valid = 1'b1; b0.req_op = op; b0.req_addr = a; b0.req_wdata = wd; b0.req_wrstb = 4'hF;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("w0 %0d k%0d sram_en", id, k), 32'(b0.sram_en), 32'(k == 1));
      chk($sformatf("w0 %0d k%0d rsp_valid", id, k), 32'(b0.rsp_valid), 32'(k == 2));
      if (k == 1) chk($sformatf("w0 %0d sram_addr", id), 32'(b0.sram_addr), 32'h10);
      if (k == 2 && op == LD) chk($sformatf("w0 %0d rsp_rdata", id), b0.rsp_rdata, erd);
    end
    @(posedge clk); #1;
    b0.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.req_valid = 1'b0; b1.req_op = 2'b00; b1.req_addr = '0; b1.req_wdata = '0; b1.req_wrstb = '0;
    b0.req_valid = 1'b0; b0.req_op = 2'b00; b0.req_addr = '0; b0.req_wdata = '0; b0.req_wrstb = '0;

    vt[0] = '{ST, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 12'h004, 4'hF, 32'h0000_0000};
    vt[1] = '{LD, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 12'h004, 4'h0, 32'hDEAD_BEEF};
    vt[2] = '{ST, 32'h0000_4010, 32'h00AA_0000, 4'h4, 1'b0, 12'h004, 4'h4, 32'hDEAD_BEEF};
    vt[3] = '{LD, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 12'h004, 4'h0, 32'hDEAA_BEEF};
    vt[4] = '{ST, 32'h0000_3FFC, 32'h1234_5678, 4'hF, 1'b0, 12'hFFF, 4'hF, 32'hDEAA_BEEF};
    vt[5] = '{ST, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 12'h004, 4'h0, 32'hDEAA_BEEF};
    vt[6] = '{LD, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 12'h004, 4'h0, 32'hDEAA_BEEF};
    vt[7] = '{LD, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b0, 12'hFFF, 4'h0, 32'h1234_5678};
`ifdef DMEM_MISALIGN_CHECK_EN
    vt[8]  = '{LD, 32'h0000_0012, 32'h0,         4'hF, 1'b1, 12'h000, 4'h0, 32'h1234_5678};
    vt[9]  = '{ST, 32'h0000_0011, 32'h0000_5555, 4'h3, 1'b1, 12'h000, 4'h0, 32'h1234_5678};
    vt[10] = '{LD, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 12'h004, 4'h0, 32'hDEAA_BEEF};
    w4 = 32'hDEAA_BEEF;
`else
    vt[8]  = '{LD, 32'h0000_0012, 32'h0,         4'hF, 1'b0, 12'h004, 4'h0, 32'hDEAA_BEEF};
    vt[9]  = '{ST, 32'h0000_0011, 32'h0000_5555, 4'h3, 1'b0, 12'h004, 4'h3, 32'hDEAA_BEEF};
    vt[10] = '{LD, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 12'h004, 4'h0, 32'hDEAA_5555};
    w4 = 32'hDEAA_5555;
`endif

    // Reset values while rst_n is held low.
    #2;
    chk("rst req_ready", 32'(b1.req_ready), 32'd1);
    chk("rst stall", 32'(b1.stall), 32'd0);
    chk("rst rsp_valid", 32'(b1.rsp_valid), 32'd0);
    chk("rst rsp_rdata", b1.rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(b1.rsp_err), 32'd0);
    chk("rst sram_en", 32'(b1.sram_en), 32'd0);
    chk("rst sram_we", 32'(b1.sram_we), 32'd0);
    chk("rst sram_addr", 32'(b1.sram_addr), 32'd0);
    chk("rst sram_wdata", b1.sram_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // NONE / 11 with req_valid high: never accepted, no stall.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      b1.req_valid = 1'b1; b1.req_op = (c < 5) ? 2'b00 : 2'b11; b1.req_addr = 32'h10;
      @(negedge clk);
      chk($sformatf("idle%0d stall", c), 32'(b1.stall), 32'd0);
      chk($sformatf("idle%0d sram_en", c), 32'(b1.sram_en), 32'd0);
      chk($sformatf("idle%0d req_ready", c), 32'(b1.req_ready), 32'd1);
    end

    // Table: issued back to back with req_valid held across each RESP.
    for (int v = 0; v < 11; v++) xact(vt[v], v);

    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    @(negedge clk);
    chk("post rsp_valid", 32'(b1.rsp_valid), 32'd0);
    chk("post req_ready", 32'(b1.req_ready), 32'd1);
    chk("post sram_en", 32'(b1.sram_en), 32'd0);
    chk("post sram_addr", 32'(b1.sram_addr), 32'd0);

    // Reset asserted mid-cycle during WAIT drops the pending store.
    @(posedge clk); #1;
    b1.req_valid = 1'b1; b1.req_op = ST; b1.req_addr = 32'h10;
    b1.req_wdata = 32'hCAFE_F00D; b1.req_wrstb = 4'hF;
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    chk("wait req_ready", 32'(b1.req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst req_ready", 32'(b1.req_ready), 32'd1);
    chk("mid-rst rsp_rdata", b1.rsp_rdata, 32'd0);
    chk("mid-rst sram_en", 32'(b1.sram_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("after-rst%0d sram_en", c), 32'(b1.sram_en), 32'd0);
      chk($sformatf("after-rst%0d rsp_valid", c), 32'(b1.rsp_valid), 32'd0);
    end
    xact('{LD, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 12'h004, 4'h0, w4}, 11);

    // Zero wait states: sram_en at T+1, rsp_valid at T+2.
    x0(ST, 32'h0000_0040, 32'hA5A5_5A5A, 32'h0, 0);
    x0(LD, 32'h0000_0040, 32'h0, 32'hA5A5_5A5A, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
